// File: rtl/asm_pass_controller.sv
// Two-pass character sequencer for the assembler front end: BRAM fetch, valid/ready
// presentation, per-line classification with line/PC tracking. Option: ASM_CR_STRIP_EN.
module asm_pass_controller #(
  parameter int NUMBER_LINES = 256,
  parameter int MAX_CHARS    = 4096,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              start_in,
  input  logic [$clog2(MAX_CHARS):0]        text_len_in,
  output logic [$clog2(MAX_CHARS)-1:0]      addr_out,
  input  logic [7:0]                        data_in,
  output logic [7:0]                        char_out,
  output logic                              char_valid_out,
  input  logic                              char_ready_in,
  output logic                              new_line_out,
  output logic [$clog2(NUMBER_LINES)+1:0]   pc_out,
  output logic [$clog2(MAX_CHARS)-1:0]      line_out,
  output logic                              pass_out,
  output logic                              busy_out,
  output logic                              done_out,
  output logic                              overflow_out
);
  localparam int AW = $clog2(MAX_CHARS);
  localparam int PW = $clog2(NUMBER_LINES) + 2;
  localparam int CW = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;
  localparam logic [PW-1:0] PC_LAST = PW'(NUMBER_LINES * 4 - 4);
  localparam logic [CW-1:0] WAIT_LAST = CW'(BRAM_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, PASS_END, DONE} state_t;
  state_t state, state_nxt;

  logic [AW:0]    addr, len;
  logic [CW-1:0]  wcnt;
  logic [7:0]     ch;
  logic [PW-1:0]  pc;
  logic [AW-1:0]  line;
  logic           pass, ovf;
  logic           seen, alpha, colon, hash;
  logic           n_seen, n_alpha, n_colon, n_hash;
  logic           is_cr, is_nl, is_ws, is_alpha, skip, xfer, last, line_end, instr;

  always_comb begin
    is_cr    = (ch == 8'h0D);
    is_nl    = (ch == 8'h0A);
    is_ws    = (ch == 8'h20) || (ch == 8'h09) || is_cr;
    is_alpha = ((ch >= 8'h41) && (ch <= 8'h5A)) || ((ch >= 8'h61) && (ch <= 8'h7A));
`ifdef ASM_CR_STRIP_EN
    skip     = is_cr;
`else
    skip     = 1'b0;
`endif
    // A stripped CR completes its slot without a handshake.
    xfer     = (state == PRESENT) && (char_ready_in || skip);
    last     = ((addr + 1'b1) == len);
    n_seen   = seen | (!is_ws && !is_nl);
    n_alpha  = seen ? alpha : is_alpha;
    n_colon  = colon | ((ch == 8'h3A) && !hash);
    n_hash   = hash | (ch == 8'h23);
    line_end = xfer && (is_nl || last);
    instr    = skip ? (alpha && !colon) : (n_alpha && !n_colon);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_in) state_nxt = (text_len_in == '0) ? PASS_END : FETCH;
      FETCH:    state_nxt = WAIT;
      WAIT:     if (wcnt == WAIT_LAST) state_nxt = PRESENT;
      PRESENT:  if (xfer) state_nxt = last ? PASS_END : FETCH;
      PASS_END: if (!pass) state_nxt = (len == '0) ? PASS_END : FETCH;
                else state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      addr  <= '0;
      len   <= '0;
      wcnt  <= '0;
      ch    <= '0;
      pc    <= '0;
      line  <= '0;
      pass  <= 1'b0;
      ovf   <= 1'b0;
      seen  <= 1'b0;
      alpha <= 1'b0;
      colon <= 1'b0;
      hash  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_in) begin
        len   <= text_len_in;
        addr  <= '0;
        pass  <= 1'b0;
        pc    <= '0;
        line  <= '0;
        ovf   <= 1'b0;
        seen  <= 1'b0;
        alpha <= 1'b0;
        colon <= 1'b0;
        hash  <= 1'b0;
      end
      if (state == FETCH) wcnt <= '0;
      if (state == WAIT) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == WAIT_LAST) ch <= data_in;
      end
      if (xfer) begin
        addr <= addr + 1'b1;
        if (!skip) begin
          seen  <= is_nl ? 1'b0 : n_seen;
          alpha <= is_nl ? 1'b0 : n_alpha;
          colon <= is_nl ? 1'b0 : n_colon;
          hash  <= is_nl ? 1'b0 : n_hash;
        end
        if (line_end && instr) begin
          pc <= (pc == PC_LAST) ? '0 : pc + PW'(4);
          if (pc == PC_LAST) ovf <= 1'b1;
        end
        if (is_nl) line <= line + 1'b1;
      end
      if (state == PASS_END && !pass) begin
        pass  <= 1'b1;
        pc    <= '0;
        line  <= '0;
        addr  <= '0;
        seen  <= 1'b0;
        alpha <= 1'b0;
        colon <= 1'b0;
        hash  <= 1'b0;
      end
    end
  end

  assign addr_out       = addr[AW-1:0];
  assign char_out       = ch;
  assign char_valid_out = (state == PRESENT) && !skip;
  assign new_line_out   = xfer && is_nl;
  assign pc_out         = pc;
  assign line_out       = line;
  assign pass_out       = pass;
  assign busy_out       = (state == FETCH) || (state == WAIT) || (state == PRESENT) || (state == PASS_END);
  assign done_out       = (state == DONE);
  assign overflow_out   = ovf;
endmodule
